// File: rtl/fpu_interco_pkg.sv
// -----------------------------------------------------------------------------
// fpu_interco_pkg
// Shared definitions for the FPU interconnect response path.
//   - Default sizing localparams (core count / ID width, tracker depth,
//     result and flag widths).
//   - fpu_resp_t: response bundle (valid, one-hot ID, result, flags) at the
//     default widths.
// No ports; imported by the tracker and its FIFO.
// -----------------------------------------------------------------------------
package fpu_interco_pkg;

  localparam int unsigned NB_CORES_DEF   = 8;
  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned FLAG_WIDTH_DEF = 5;

  typedef struct packed {
    logic                      valid;
    logic [NB_CORES_DEF-1:0]   id;
    logic [DATA_WIDTH_DEF-1:0] rdata;
    logic [FLAG_WIDTH_DEF-1:0] flags;
  } fpu_resp_t;

endpackage

// File: rtl/fpu_resp_id_tracker_if.sv
// -----------------------------------------------------------------------------
// fpu_resp_id_tracker_if
// Bundles the issue-side, FPU-side and response-side signals of the tracker.
//   master: drives issue_valid_i/issue_ID_i and fpu_valid_i/fpu_result_i/
//           fpu_flags_i; observes ready, response and error outputs.
//   slave : the tracker itself (opposite directions).
// -----------------------------------------------------------------------------
interface fpu_resp_id_tracker_if #(
  parameter int unsigned NB_CORES   = fpu_interco_pkg::NB_CORES_DEF,
  parameter int unsigned DATA_WIDTH = fpu_interco_pkg::DATA_WIDTH_DEF,
  parameter int unsigned FLAG_WIDTH = fpu_interco_pkg::FLAG_WIDTH_DEF
) ();

  logic                  issue_valid_i;
  logic [NB_CORES-1:0]   issue_ID_i;
  logic                  issue_ready_o;
  logic                  fpu_valid_i;
  logic [DATA_WIDTH-1:0] fpu_result_i;
  logic [FLAG_WIDTH-1:0] fpu_flags_i;
  logic                  data_r_valid_o;
  logic [NB_CORES-1:0]   data_ID_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic [FLAG_WIDTH-1:0] data_r_flags_o;
  logic                  err_underflow_o;
  logic                  err_onehot_o;

  modport master (
    output issue_valid_i, issue_ID_i, fpu_valid_i, fpu_result_i, fpu_flags_i,
    input  issue_ready_o, data_r_valid_o, data_ID_o, data_r_rdata_o, data_r_flags_o,
    input  err_underflow_o, err_onehot_o
  );

  modport slave (
    input  issue_valid_i, issue_ID_i, fpu_valid_i, fpu_result_i, fpu_flags_i,
    output issue_ready_o, data_r_valid_o, data_ID_o, data_r_rdata_o, data_r_flags_o,
    output err_underflow_o, err_onehot_o
  );

endinterface

// File: rtl/fpu_id_fifo.sv
// -----------------------------------------------------------------------------
// fpu_id_fifo
// Circular FIFO of DEPTH entries (any DEPTH >= 2) holding in-flight core IDs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push_req   request to store i_wdata (ignored when full)
//   i_wdata      ID to store
//   i_pop_req    request to release the head (ignored when empty)
//   o_push       push actually performed this cycle
//   o_pop        pop actually performed this cycle
//   o_ready      not full (occupancy of this cycle, no pop bypass)
//   o_empty      occupancy is zero
//   o_rdata      current head entry
// -----------------------------------------------------------------------------
module fpu_id_fifo #(
  parameter int unsigned DEPTH = fpu_interco_pkg::DEPTH_DEF,
  parameter int unsigned WIDTH = fpu_interco_pkg::NB_CORES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_req,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop_req,
  output logic             o_push,
  output logic             o_pop,
  output logic             o_ready,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];
  ptr_t             r_wptr;
  ptr_t             r_rptr;
  logic [CNT_W-1:0] r_count;

  assign o_ready = (r_count != CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_push  = i_push_req & o_ready;
  assign o_pop   = i_pop_req & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (o_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (o_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (o_push && !o_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (o_pop && !o_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_resp_id_tracker.sv
// -----------------------------------------------------------------------------
// fpu_resp_id_tracker
// In-order ID tracker for the shared FPU response path. Records the one-hot ID
// of each accepted FPU operation and tags each FPU result with the oldest one.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  issue_valid_i/issue_ID_i/issue_ready_o  issue side
//                fpu_valid_i/fpu_result_i/fpu_flags_i    FPU result side
//                data_r_valid_o/data_ID_o/data_r_rdata_o/data_r_flags_o  response
//                err_underflow_o, err_onehot_o           sticky error flags
// Configuration macro FPU_RESP_OUT_REG_EN:
//   defined   -> response outputs registered (1-cycle latency)
//   undefined -> response outputs combinational (0-cycle latency)
// -----------------------------------------------------------------------------
module fpu_resp_id_tracker
  import fpu_interco_pkg::*;
#(
  parameter int unsigned NB_CORES   = NB_CORES_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FLAG_WIDTH = FLAG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fpu_resp_id_tracker_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [NB_CORES-1:0]   id;
    logic [DATA_WIDTH-1:0] rdata;
    logic [FLAG_WIDTH-1:0] flags;
  } resp_t;

  logic                w_push;
  logic                w_pop;
  logic                w_ready;
  logic                w_empty;
  logic [NB_CORES-1:0] w_head;
  resp_t               w_resp;
  logic                r_err_underflow;
  logic                r_err_onehot;

  fpu_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NB_CORES)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_req (bus.issue_valid_i),
    .i_wdata    (bus.issue_ID_i),
    .i_pop_req  (bus.fpu_valid_i),
    .o_push     (w_push),
    .o_pop      (w_pop),
    .o_ready    (w_ready),
    .o_empty    (w_empty),
    .o_rdata    (w_head)
  );

  assign bus.issue_ready_o = w_ready;

  // A result with nothing tracked is dropped and flagged; FIFO is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_underflow <= 1'b0;
      r_err_onehot    <= 1'b0;
    end else begin
      if (bus.fpu_valid_i && w_empty) begin
        r_err_underflow <= 1'b1;
      end
      if (w_push && ($countones(bus.issue_ID_i) != 1)) begin
        r_err_onehot <= 1'b1;
      end
    end
  end

  assign bus.err_underflow_o = r_err_underflow;
  assign bus.err_onehot_o    = r_err_onehot;

  // Idle responses are all-zero so the decoder never sees a stale ID.
  always_comb begin
    w_resp = '0;
    if (w_pop) begin
      w_resp.valid = 1'b1;
      w_resp.id    = w_head;
      w_resp.rdata = bus.fpu_result_i;
      w_resp.flags = bus.fpu_flags_i;
    end
  end

`ifdef FPU_RESP_OUT_REG_EN
  resp_t r_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp <= '0;
    end else begin
      r_resp <= w_resp;
    end
  end

  assign bus.data_r_valid_o = r_resp.valid;
  assign bus.data_ID_o      = r_resp.id;
  assign bus.data_r_rdata_o = r_resp.rdata;
  assign bus.data_r_flags_o = r_resp.flags;
`else
  assign bus.data_r_valid_o = w_resp.valid;
  assign bus.data_ID_o      = w_resp.id;
  assign bus.data_r_rdata_o = w_resp.rdata;
  assign bus.data_r_flags_o = w_resp.flags;
`endif

endmodule

// File: tb/tb_fpu_resp_id_tracker.sv
// -----------------------------------------------------------------------------
// tb_fpu_resp_id_tracker
// Directed bench for fpu_resp_id_tracker: one DEPTH=4 instance and one DEPTH=3
// instance. Response checks follow the build's latency (FPU_RESP_OUT_REG_EN).
// -----------------------------------------------------------------------------
module tb_fpu_resp_id_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fpu_resp_id_tracker_if #(.NB_CORES(8), .DATA_WIDTH(32), .FLAG_WIDTH(5)) bus  ();
  fpu_resp_id_tracker_if #(.NB_CORES(8), .DATA_WIDTH(32), .FLAG_WIDTH(5)) bus3 ();

  fpu_resp_id_tracker #(
    .NB_CORES (8), .DEPTH (4), .DATA_WIDTH (32), .FLAG_WIDTH (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  fpu_resp_id_tracker #(
    .NB_CORES (8), .DEPTH (3), .DATA_WIDTH (32), .FLAG_WIDTH (5)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one FPU result on dut and check the tagged response at the
  // point where it becomes visible for this build.
  task automatic pop_step(input logic [31:0] res, input logic [4:0] fl,
                          input logic [7:0] exp_id, input string tag);
    bus.fpu_valid_i  = 1'b1;
    bus.fpu_result_i = res;
    bus.fpu_flags_i  = fl;
`ifdef FPU_RESP_OUT_REG_EN
    tick();
`else
    #1;
`endif
    chk({tag, "_valid"}, 64'(bus.data_r_valid_o), 64'(1));
    chk({tag, "_id"},    64'(bus.data_ID_o),      64'(exp_id));
    chk({tag, "_rdata"}, 64'(bus.data_r_rdata_o), 64'(res));
    chk({tag, "_flags"}, 64'(bus.data_r_flags_o), 64'(fl));
`ifndef FPU_RESP_OUT_REG_EN
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] id;
    logic [7:0] exp_id;

    bus.issue_valid_i  = 1'b0;  bus.issue_ID_i  = '0;
    bus.fpu_valid_i    = 1'b0;  bus.fpu_result_i = '0;  bus.fpu_flags_i  = '0;
    bus3.issue_valid_i = 1'b0;  bus3.issue_ID_i = '0;
    bus3.fpu_valid_i   = 1'b0;  bus3.fpu_result_i = '0; bus3.fpu_flags_i = '0;

    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", 64'(bus.issue_ready_o),   64'(1));
    chk("rst_valid", 64'(bus.data_r_valid_o),  64'(0));
    chk("rst_id",    64'(bus.data_ID_o),       64'(0));
    chk("rst_rdata", 64'(bus.data_r_rdata_o),  64'(0));
    chk("rst_uflow", 64'(bus.err_underflow_o), 64'(0));
    chk("rst_1hot",  64'(bus.err_onehot_o),    64'(0));
    chk("rst_count", 64'(dut.u_fifo.r_count),  64'(0));

    // Single push / result
    bus.issue_valid_i = 1'b1; bus.issue_ID_i = 8'h04;
    tick();
    bus.issue_valid_i = 1'b0;
    pop_step(32'h3F80_0000, 5'h01, 8'h04, "single");
    bus.fpu_valid_i = 1'b0;
    chk("single_count", 64'(dut.u_fifo.r_count), 64'(0));
    tick();
    chk("idle_valid", 64'(bus.data_r_valid_o), 64'(0));
    chk("idle_id",    64'(bus.data_ID_o),      64'(0));

    // Fill to DEPTH=4, fifth push ignored, drain in order
    bus.issue_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.issue_ID_i = 8'h01 << i;
      tick();
    end
    chk("full_ready", 64'(bus.issue_ready_o),  64'(0));
    chk("full_count", 64'(dut.u_fifo.r_count), 64'(4));
    bus.issue_ID_i = 8'h10;
    tick();
    bus.issue_valid_i = 1'b0;
    chk("ovf_ready", 64'(bus.issue_ready_o),  64'(0));
    chk("ovf_count", 64'(dut.u_fifo.r_count), 64'(4));
    pop_step(32'h0000_0011, 5'h02, 8'h01, "drain0");
    pop_step(32'h0000_0022, 5'h04, 8'h02, "drain1");
    pop_step(32'h0000_0033, 5'h08, 8'h04, "drain2");
    pop_step(32'h0000_0044, 5'h10, 8'h08, "drain3");
    bus.fpu_valid_i = 1'b0;
    chk("drain_ready", 64'(bus.issue_ready_o),  64'(1));
    chk("drain_count", 64'(dut.u_fifo.r_count), 64'(0));

    // Result with nothing tracked
    bus.fpu_valid_i = 1'b1; bus.fpu_result_i = 32'hDEAD_BEEF;
    tick();
    bus.fpu_valid_i = 1'b0;
    chk("uflow_valid", 64'(bus.data_r_valid_o),  64'(0));
    chk("uflow_id",    64'(bus.data_ID_o),       64'(0));
    chk("uflow_err",   64'(bus.err_underflow_o), 64'(1));
    chk("uflow_count", 64'(dut.u_fifo.r_count),  64'(0));

    // Non-one-hot ID is still tracked
    bus.issue_valid_i = 1'b1; bus.issue_ID_i = 8'h05;
    tick();
    bus.issue_valid_i = 1'b0;
    chk("onehot_err", 64'(bus.err_onehot_o), 64'(1));
    pop_step(32'h4000_0000, 5'h10, 8'h05, "onehot_resp");
    bus.fpu_valid_i = 1'b0;
    chk("uflow_sticky", 64'(bus.err_underflow_o), 64'(1));
    chk("onehot_sticky", 64'(bus.err_onehot_o),   64'(1));

    // DEPTH=3: preload two, then ten cycles of simultaneous push/pop
    bus3.issue_valid_i = 1'b1;
    bus3.issue_ID_i = 8'h01; tick(); q.push_back(8'h01);
    bus3.issue_ID_i = 8'h02; tick(); q.push_back(8'h02);
    for (int k = 0; k < 10; k++) begin
      id = 8'h01 << ((k + 2) % 8);
      bus3.issue_ID_i   = id;
      bus3.fpu_valid_i  = 1'b1;
      bus3.fpu_result_i = 32'(k);
      exp_id = q.pop_front();
      q.push_back(id);
`ifdef FPU_RESP_OUT_REG_EN
      tick();
`else
      #1;
`endif
      chk("wrap_valid", 64'(bus3.data_r_valid_o), 64'(1));
      chk("wrap_id",    64'(bus3.data_ID_o),      64'(exp_id));
`ifndef FPU_RESP_OUT_REG_EN
      tick();
`endif
      chk("wrap_count", 64'(dut3.u_fifo.r_count), 64'(2));
    end
    bus3.issue_valid_i = 1'b0;
    bus3.fpu_valid_i   = 1'b0;
    // 12 pushes and 10 pops modulo 3
    chk("wrap_wptr", 64'(dut3.u_fifo.r_wptr), 64'(0));
    chk("wrap_rptr", 64'(dut3.u_fifo.r_rptr), 64'(1));

    // Asynchronous reset with three IDs tracked
    bus.issue_valid_i = 1'b1;
    bus.issue_ID_i = 8'h01; tick();
    bus.issue_ID_i = 8'h02; tick();
    bus.issue_ID_i = 8'h04; tick();
    bus.issue_valid_i = 1'b0;
    chk("pre_rst_count", 64'(dut.u_fifo.r_count), 64'(3));
    bus.fpu_valid_i = 1'b1; bus.fpu_result_i = 32'h1234_5678; bus.fpu_flags_i = 5'h03;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(dut.u_fifo.r_count),  64'(0));
    chk("arst_ready", 64'(bus.issue_ready_o),   64'(1));
    chk("arst_valid", 64'(bus.data_r_valid_o),  64'(0));
    chk("arst_id",    64'(bus.data_ID_o),       64'(0));
    chk("arst_rdata", 64'(bus.data_r_rdata_o),  64'(0));
    chk("arst_flags", 64'(bus.data_r_flags_o),  64'(0));
    chk("arst_uflow", 64'(bus.err_underflow_o), 64'(0));
    chk("arst_1hot",  64'(bus.err_onehot_o),    64'(0));
    #2;
    rst_n = 1'b1;
    // In-flight result after release has no tracked owner
    tick();
    bus.fpu_valid_i = 1'b0;
    chk("post_rst_uflow", 64'(bus.err_underflow_o), 64'(1));
    chk("post_rst_valid", 64'(bus.data_r_valid_o),  64'(0));
    chk("post_rst_count", 64'(dut.u_fifo.r_count),  64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_resp_id_tracker.md
# fpu_resp_id_tracker

In-order ID tracker for the shared FPU response path. It records the one-hot core ID of every operation the shared FPU accepts. When the FPU produces a result, it pops the oldest ID and presents the result, flags, valid and ID to the response address decoder, which fans `data_r_valid` out per core. It sits between the shared FPU's output and that decoder, and is fed by the request-side grant.

## Interface
Parameters:
- `NB_CORES`, 8: number of cores; also the ID width (the ID is one-hot).
- `DEPTH`, 4: maximum in-flight FPU operations; must be ≥ 2; any integer, not limited to powers of two.
- `DATA_WIDTH`, 32: result width.
- `FLAG_WIDTH`, 5: FPU status flag width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `issue_valid_i`  in  1  operation accepted by the FPU this cycle (request valid AND grant).
- `issue_ID_i`  in  NB_CORES  one-hot ID of the issuing core.
- `issue_ready_o`  out  1  tracker can record a new ID; request arbiter must gate its grant with this.
- `fpu_valid_i`  in  1  FPU result valid (no backpressure toward the FPU).
- `fpu_result_i`  in  DATA_WIDTH  result.
- `fpu_flags_i`  in  FLAG_WIDTH  status flags.
- `data_r_valid_o`  out  1  response valid to the decoder.
- `data_ID_o`  out  NB_CORES  one-hot ID of the response's owner.
- `data_r_rdata_o`  out  DATA_WIDTH  result to cores.
- `data_r_flags_o`  out  FLAG_WIDTH  flags to cores.
- `err_underflow_o`  out  1  sticky: FPU result arrived while no ID was tracked.
- `err_onehot_o`  out  1  sticky: a non-one-hot `issue_ID_i` was pushed.

## Operation
- Circular FIFO of `DEPTH` IDs with write pointer, read pointer and occupancy counter (width `$clog2(DEPTH+1)`).
- Pointers wrap from `DEPTH-1` to 0 explicitly; power-of-two rollover must not be relied on.
- Push: `issue_valid_i && issue_ready_o`; writes `issue_ID_i` at the write pointer and advances it.
- Pop: `fpu_valid_i && count != 0`; reads the ID at the read pointer and advances it.
- `issue_ready_o = (count != DEPTH)`. No same-cycle pop-frees-slot bypass; a full FIFO stays not-ready for that cycle.
- Push while not ready is ignored: no state change.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any occupancy from 1 to DEPTH−1.
- Push into an empty FIFO is not visible to a pop in the same cycle. The FPU has latency ≥ 1.
- `fpu_valid_i` with count == 0:
  - no response is emitted;
  - `err_underflow_o` sets;
  - pointers and count are unchanged.
- A push with `$countones(issue_ID_i) != 1` still stores the ID and sets `err_onehot_o`.
- Sticky errors clear only on reset.

## Timing
- Reset (async assert, sync release): pointers 0, count 0, `issue_ready_o` = 1, all `data_*` outputs 0, both error flags 0.
- With the output register (default), response latency is 1 cycle. If `fpu_valid_i` is high in cycle N, then in N+1:
  - `data_r_valid_o` = 1;
  - ID, result and flags come from cycle N.
- Output registers update every cycle. Data and ID are zeroed when valid is 0, so the decoder sees all-zero IDs when idle.
- Back-to-back FPU results every cycle are supported at full throughput.
- Reset asserted mid-operation discards all tracked IDs immediately. An in-flight FPU result arriving after release is an underflow.

## Configuration
- `FPU_RESP_OUT_REG_EN`:
  - Defined: outputs are registered as in Timing (1-cycle latency).
  - Undefined: outputs are combinational from `fpu_valid_i`, the FIFO head and the FPU data (0-cycle latency). They are still forced to zero when no pop occurs.
  - FIFO and error behaviour are identical in both builds.

## Structure
- Shared package `fpu_interco_pkg`: `DEPTH` default, and a `fpu_resp_t` struct (valid, ID, rdata, flags) parameterised via localparams there.
- One natural sub-module, `fpu_id_fifo`, holding storage, pointers and count. The top adds the output stage and error logic.

## Test plan
- Reset, then push ID 8'h04, then `fpu_valid_i` with result 32'h3F800000 and flags 5'h01:
  - one cycle later, valid=1, ID=8'h04, rdata=32'h3F800000, flags=5'h01;
  - count returns to 0.
- Push 8'h01, 8'h02, 8'h04, 8'h08 back-to-back with DEPTH=4:
  - `issue_ready_o` = 0 after the fourth push;
  - a fifth push is ignored;
  - four consecutive results return IDs in order 01, 02, 04, 08.
- DEPTH=3 with continuous simultaneous push/pop for 10 cycles: pointers wrap 2→0, IDs stay in order, count stays constant.
- `fpu_valid_i` with the FIFO empty: `data_r_valid_o` stays 0, `err_underflow_o` = 1 and stays 1 until reset.
- Push 8'h05: `err_onehot_o` = 1, and the later response carries ID 8'h05.
- Assert `rst_n` low with 3 IDs tracked: outputs and count are 0 asynchronously and `issue_ready_o` = 1. In a build without `FPU_RESP_OUT_REG_EN`, the response appears in the same cycle as `fpu_valid_i`.
